// File: rtl/aes128_rsm_ctrl_pkg.sv
// Shared types and constants for the AES-128 rotating-shuffle-mask core controller.
package aes128_rsm_ctrl_pkg;

  localparam int unsigned       LFSR_W       = 16;
  // Galois taps for x^16+x^14+x^13+x^11+1, right-shifting form
  localparam logic [LFSR_W-1:0] LFSR_POLY    = 16'hB400;
  localparam int unsigned       CORE_LATENCY = 11;

  typedef enum logic [2:0] {
    IDLE,
    LOADKEY,
    START,
    WAIT,
    ERROR
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/aes128_rsm_ctrl_lfsr.sv
// 16-bit Galois LFSR supplying the per-encryption rotate offset.
module rsm_rotate_lfsr
  import aes128_rsm_ctrl_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [3:0]        rot
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  // A zero seed would lock the register up, so it maps to SEED; load beats step.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (load_val == '0) ? SEED : load_val;
    end else if (step) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign rot = lfsr_q[3:0];

endmodule

// File: rtl/aes128_rsm_ctrl.sv
// Sequences key load, start and completion of an external masked AES-128 core,
// with output buffering, a completion timeout and an encryption counter.
module aes128_rsm_ctrl
  import aes128_rsm_ctrl_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned       TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [127:0]      key_in,
  input  logic              key_we,
  output logic              key_ready,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              seed_we,
  input  logic              cfg_rand_en,
  input  logic [3:0]        cfg_rotate,
  input  logic [127:0]      in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [127:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              trigger,
  output logic              err,
  input  logic              err_clr,
  output logic [31:0]       enc_count,
  output logic [127:0]      core_key,
  output logic              core_key_valid,
  output logic [127:0]      core_plaintext,
  output logic              core_plaintext_valid,
  output logic [3:0]        core_rotate,
  input  logic [127:0]      core_ciphertext,
  input  logic              core_ciphertext_valid,
  input  logic              core_busy
);

  localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [127:0]        key_q, key_d;
  logic                key_loaded_q, key_loaded_d;
  logic [127:0]        pt_q, pt_d;
  logic [3:0]          rot_q, rot_d;
  logic [127:0]        out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [31:0]         enc_count_q, enc_count_d;
  logic                err_q, err_d;
  logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                live_q;
  logic [3:0]          lfsr_rot;
  logic                accept;
  logic                key_wr;
  logic                ct_take;
  logic                timeout_hit;

  assign accept      = in_valid && in_ready;
  assign key_wr      = key_we && key_ready;
  assign ct_take     = (state_q == WAIT) && core_ciphertext_valid;
  assign timeout_hit = (state_q == WAIT) && !core_ciphertext_valid
                       && (wait_cnt_q == WCNT_W'(TIMEOUT - 1));

  rsm_rotate_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk      (clk),
    .reset_n  (reset_n),
    .step     (accept),
    .load     (seed_we),
    .load_val (seed_in),
    .rot      (lfsr_rot)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = LOADKEY;
      LOADKEY: state_d = START;
      START:   state_d = WAIT;
      WAIT: begin
        if (core_ciphertext_valid) begin
          state_d = IDLE;
        end else if (timeout_hit) begin
          state_d = ERROR;
        end
      end
      ERROR:   if (err_clr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // key_ready is held low for the first cycle out of reset so every output reads 0 during reset.
  always_comb begin
    key_ready            = live_q && (state_q == IDLE);
    in_ready             = (state_q == IDLE) && key_loaded_q && !out_valid_q
                           && !core_busy && !err_q;
    core_key_valid       = (state_q == LOADKEY);
    core_plaintext_valid = (state_q == START);
    trigger              = (state_q == START) || (state_q == WAIT);
  end

  always_comb begin
    key_d        = key_q;
    key_loaded_d = key_loaded_q;
    if (key_wr) begin
      key_d        = key_in;
      key_loaded_d = 1'b1;
    end

    pt_d  = pt_q;
    rot_d = rot_q;
    if (accept) begin
      pt_d  = in_data;
      rot_d = cfg_rand_en ? lfsr_rot : cfg_rotate;
    end

    wait_cnt_d = '0;
    if ((state_q == START) || (state_q == WAIT)) begin
      wait_cnt_d = wait_cnt_q + WCNT_W'(1);
    end

    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    enc_count_d = enc_count_q;
    if (ct_take) begin
      out_data_d  = core_ciphertext;
      out_valid_d = 1'b1;
      enc_count_d = enc_count_q + 32'd1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // A timeout in the same cycle as err_clr wins.
    err_d = err_q;
    if (timeout_hit) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q        <= '0;
      key_loaded_q <= 1'b0;
      pt_q         <= '0;
      rot_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      enc_count_q  <= '0;
      err_q        <= 1'b0;
      wait_cnt_q   <= '0;
      live_q       <= 1'b0;
    end else begin
      key_q        <= key_d;
      key_loaded_q <= key_loaded_d;
      pt_q         <= pt_d;
      rot_q        <= rot_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      enc_count_q  <= enc_count_d;
      err_q        <= err_d;
      wait_cnt_q   <= wait_cnt_d;
      live_q       <= 1'b1;
    end
  end

  assign out_data       = out_data_q;
  assign out_valid      = out_valid_q;
  assign enc_count      = enc_count_q;
  assign err            = err_q;
  assign core_key       = key_q;
  assign core_plaintext = pt_q;
  assign core_rotate    = rot_q;

endmodule

// File: tb/tb_aes128_rsm_ctrl.sv
// Directed bench for aes128_rsm_ctrl with a behavioural core model and result scoreboard.
module tb_aes128_rsm_ctrl;
  import aes128_rsm_ctrl_pkg::*;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY2     = 128'hdeadbeef_01234567_89abcdef_cafef00d;
  localparam logic [127:0] PT2      = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  localparam int unsigned  LAT      = 14;

  typedef struct {
    logic [127:0] ct;
    logic [3:0]   rot;
    int unsigned  acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [127:0] key_in;
  logic         key_we;
  logic         key_ready;
  logic [15:0]  seed_in;
  logic         seed_we;
  logic         cfg_rand_en;
  logic [3:0]   cfg_rotate;
  logic [127:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         trigger;
  logic         err;
  logic         err_clr;
  logic [31:0]  enc_count;
  logic [127:0] core_key;
  logic         core_key_valid;
  logic [127:0] core_plaintext;
  logic         core_plaintext_valid;
  logic [3:0]   core_rotate;
  logic [127:0] core_ciphertext = '0;
  logic         core_ciphertext_valid = 1'b0;
  logic         core_busy;

  exp_t         sb[$];
  exp_t         mon_e;
  int unsigned  n_tests = 0;
  int unsigned  n_fail  = 0;
  int unsigned  cyc     = 0;
  logic [15:0]  m_lfsr  = 16'hACE1;
  logic [31:0]  m_cnt   = '0;
  logic         ov_seen = 1'b0;
  logic         core_hang = 1'b0;
  logic         spurious  = 1'b0;
  logic [127:0] ck, cp;
  int unsigned  lat = 0;

  aes128_rsm_ctrl #(
    .LFSR_SEED (16'hACE1),
    .TIMEOUT   (16)
  ) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .key_in                (key_in),
    .key_we                (key_we),
    .key_ready             (key_ready),
    .seed_in               (seed_in),
    .seed_we               (seed_we),
    .cfg_rand_en           (cfg_rand_en),
    .cfg_rotate            (cfg_rotate),
    .in_data               (in_data),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .out_data              (out_data),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .trigger               (trigger),
    .err                   (err),
    .err_clr               (err_clr),
    .enc_count             (enc_count),
    .core_key              (core_key),
    .core_key_valid        (core_key_valid),
    .core_plaintext        (core_plaintext),
    .core_plaintext_valid  (core_plaintext_valid),
    .core_rotate           (core_rotate),
    .core_ciphertext       (core_ciphertext),
    .core_ciphertext_valid (core_ciphertext_valid),
    .core_busy             (core_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return k ^ {p[63:0], p[127:64]} ^ 128'h5a5a_0000_ffff_1234_8765_4321_0f0f_a5a5;
  endfunction

  function automatic logic [15:0] tb_step(input logic [15:0] s);
    return s[0] ? ({1'b0, s[15:1]} ^ 16'hB400) : {1'b0, s[15:1]};
  endfunction

  // Core model: completes CORE_LATENCY cycles after its start strobe unless told to hang.
  always @(posedge clk) begin
    core_ciphertext_valid <= spurious;
    if (core_key_valid) ck <= core_key;
    if (core_plaintext_valid) begin
      cp  <= core_plaintext;
      lat <= CORE_LATENCY - 1;
    end else if (lat != 0) begin
      lat <= lat - 1;
      if (lat == 1 && !core_hang) begin
        core_ciphertext_valid <= 1'b1;
        core_ciphertext       <= core_fn(ck, cp);
      end
    end
  end
  assign core_busy = (lat != 0);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (core_plaintext_valid && sb.size() != 0) begin
      chk("core_rotate", 128'(core_rotate), 128'(sb[0].rot));
      chk("trigger_start", 128'(trigger), 128'd1);
    end
    if (out_valid && !ov_seen) begin
      ov_seen = 1'b1;
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 128'(out_valid), 128'd0);
      end else begin
        mon_e = sb.pop_front();
        m_cnt = m_cnt + 32'd1;
        chk("out_data", out_data, mon_e.ct);
        chk("latency", 128'(cyc - mon_e.acc), 128'(LAT));
        chk("enc_count", 128'(enc_count), 128'(m_cnt));
        chk("trigger_done", 128'(trigger), 128'd0);
      end
    end
    if (!out_valid) ov_seen = 1'b0;
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic encrypt(input logic [127:0] pt, input logic [127:0] ct, input bit push);
    exp_t        e;
    int unsigned n;
    n        = 0;
    in_data  = pt;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick(1);
      n++;
    end
    chk("in_ready", 128'(in_ready), 128'd1);
    e.ct  = ct;
    e.rot = cfg_rand_en ? m_lfsr[3:0] : cfg_rotate;
    e.acc = cyc;
    if (seed_we) m_lfsr = (seed_in == '0) ? 16'hACE1 : seed_in;
    else         m_lfsr = tb_step(m_lfsr);
    if (push) sb.push_back(e);
    tick(1);
    in_valid = 1'b0;
    key_we   = 1'b0;
    seed_we  = 1'b0;
  endtask

  task automatic wait_out();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick(1);
      n++;
    end
    chk("out_wait_budget", 128'(sb.size()), 128'd0);
    sb.delete();
  endtask

  task automatic seed(input logic [15:0] v);
    seed_in = v;
    seed_we = 1'b1;
    tick(1);
    seed_we = 1'b0;
    m_lfsr  = (v == '0) ? 16'hACE1 : v;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; key_in = '0; key_we = 1'b0; seed_in = '0; seed_we = 1'b0;
    cfg_rand_en = 1'b0; cfg_rotate = '0; in_data = '0; in_valid = 1'b0;
    out_ready = 1'b1; err_clr = 1'b0;
    tick(3);
    chk("rst_ctrl", 128'({out_valid, in_ready, key_ready, err, trigger,
                          core_key_valid, core_plaintext_valid}), 128'd0);
    chk("rst_data", out_data | core_key | core_plaintext, 128'd0);
    chk("rst_cnt", 128'({enc_count, core_rotate}), 128'd0);
    reset_n = 1'b1;
    tick(1);
    chk("key_ready_idle", 128'(key_ready), 128'd1);
    chk("in_ready_nokey", 128'(in_ready), 128'd0);

    // Stray core completion while idle must be ignored.
    spurious = 1'b1;
    tick(1);
    spurious = 1'b0;
    tick(2);
    chk("spurious_ignored", 128'(out_valid), 128'd0);

    key_in = FIPS_KEY; key_we = 1'b1;
    tick(1);
    key_we = 1'b0;
    chk("in_ready_key", 128'(in_ready), 128'd1);

    for (int unsigned r = 0; r < 16; r++) begin
      cfg_rotate = 4'(r);
      encrypt(FIPS_PT, FIPS_CT, 1'b1);
      wait_out();
    end
    cfg_rand_en = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      encrypt(FIPS_PT, FIPS_CT, 1'b1);
      wait_out();
    end

    // Seed load in the acceptance cycle overrides the step.
    seed_in = 16'h1234; seed_we = 1'b1;
    encrypt(FIPS_PT, FIPS_CT, 1'b1);
    wait_out();
    encrypt(FIPS_PT, FIPS_CT, 1'b1);
    wait_out();
    seed(16'h0000);
    for (int unsigned i = 0; i < 2; i++) begin
      encrypt(FIPS_PT, FIPS_CT, 1'b1);
      wait_out();
    end

    // Key write in the acceptance cycle is used by that encryption.
    key_in = KEY2; key_we = 1'b1;
    encrypt(PT2, core_fn(KEY2, PT2), 1'b1);
    wait_out();
    key_in = FIPS_KEY; key_we = 1'b1;
    encrypt(FIPS_PT, FIPS_CT, 1'b1);
    wait_out();

    out_ready = 1'b0;
    encrypt(FIPS_PT, FIPS_CT, 1'b1);
    wait_out();
    for (int unsigned i = 0; i < 20; i++) begin
      chk("bp_valid", 128'(out_valid), 128'd1);
      chk("bp_data", out_data, FIPS_CT);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      tick(1);
    end
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    chk("bp_release_valid", 128'(out_valid), 128'd0);
    chk("bp_release_in_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b1;

    core_hang = 1'b1;
    encrypt(FIPS_PT, FIPS_CT, 1'b0);
    tick(16);
    chk("tmo_err_before", 128'(err), 128'd0);
    chk("tmo_trigger_wait", 128'(trigger), 128'd1);
    tick(1);
    chk("tmo_err", 128'(err), 128'd1);
    chk("tmo_error_state", 128'({key_ready, in_ready, trigger}), 128'd0);
    tick(3);
    chk("tmo_err_sticky", 128'(err), 128'd1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("err_clr", 128'(err), 128'd0);
    chk("err_clr_idle", 128'(key_ready), 128'd1);
    core_hang = 1'b0;
    encrypt(FIPS_PT, FIPS_CT, 1'b1);
    wait_out();

    core_hang = 1'b1;
    encrypt(FIPS_PT, FIPS_CT, 1'b0);
    tick(16);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("tmo_vs_clr_err", 128'(err), 128'd1);
    chk("tmo_vs_clr_state", 128'(key_ready), 128'd0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("err_clr2", 128'(err), 128'd0);
    core_hang = 1'b0;
    tick(2);

    // Reset during WAIT aborts the encryption.
    encrypt(FIPS_PT, FIPS_CT, 1'b1);
    tick(5);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", 128'({out_valid, in_ready, key_ready, err, trigger,
                              core_key_valid, core_plaintext_valid}), 128'd0);
    chk("mid_rst_data", out_data | core_key | core_plaintext, 128'd0);
    chk("mid_rst_cnt", 128'({enc_count, core_rotate}), 128'd0);
    sb.delete();
    m_cnt  = '0;
    m_lfsr = 16'hACE1;
    tick(2);
    reset_n = 1'b1;
    tick(15);
    chk("no_out_after_rst", 128'(out_valid), 128'd0);
    chk("no_key_after_rst", 128'(in_ready), 128'd0);
    key_in = KEY2; key_we = 1'b1;
    tick(1);
    key_we = 1'b0;
    encrypt(PT2, core_fn(KEY2, PT2), 1'b1);
    wait_out();

    force dut.enc_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.enc_count_q;
    m_cnt = 32'hFFFF_FFFF;
    tick(1);
    chk("cnt_preload", 128'(enc_count), 128'hFFFF_FFFF);
    encrypt(PT2, core_fn(KEY2, PT2), 1'b1);
    wait_out();
    encrypt(PT2, core_fn(KEY2, PT2), 1'b1);
    wait_out();
    chk("cnt_after_wrap", 128'(enc_count), 128'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
